// File: rtl/line_shift_ctrl.sv
// One-line delay sequencer: drives an external line FIFO so each output pixel is
// paired with the pixel above it. Optional sticky error flags under LINE_SHIFT_ERR_EN.
module line_shift_ctrl #(
  parameter int DATA_W     = 8,
  parameter int LINE_W     = 1920,
  parameter int LVL_W      = 12,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              fifo_rst,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [LVL_W-1:0]  fifo_wr_level,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_cur,
  output logic [DATA_W-1:0] out_prev,
  output logic [11:0]       line_cnt,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int PIX_W = $clog2(LINE_W + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [CLR_W-1:0]   clr_cnt;
  logic               wr_req, rd_req;
  logic               clear_entry;
  logic               line_end;

  assign line_end    = in_valid && (pix_cnt == PIX_W'(LINE_W - 1));
  assign clear_entry = (state_nxt == CLEAR) && (state != CLEAR);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    if (frame_start && state != CLEAR) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        IDLE:  ;
        CLEAR: if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = FILL;
        FILL: begin
          wr_req = in_valid;
          if (line_end) state_nxt = SHIFT;
        end
        SHIFT: begin
          wr_req = in_valid;
          rd_req = in_valid;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Guards hold even while the controller is in reset.
  assign fifo_rst     = !rst_n || (state == CLEAR);
  assign fifo_wr_en   = rst_n && wr_req && !fifo_full;
  assign fifo_rd_en   = rst_n && rd_req && !fifo_empty;
  assign fifo_wr_data = in_data;

  // FIFO read data arrives one cycle after fifo_rd_en, aligned with out_valid.
  assign out_prev = out_valid ? fifo_rd_data : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      clr_cnt   <= '0;
      line_cnt  <= '0;
      out_valid <= 1'b0;
      out_cur   <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= fifo_rd_en;
      out_cur   <= in_data;
      if (clear_entry) begin
        clr_cnt  <= '0;
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else begin
        if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        if ((state == FILL || state == SHIFT) && in_valid) begin
          if (line_end) begin
            pix_cnt <= '0;
            if (line_cnt != 12'hFFF) line_cnt <= line_cnt + 1'b1;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef LINE_SHIFT_ERR_EN
  logic ovf_evt, udf_evt;
  logic err_ovf_r, err_udf_r;

  assign ovf_evt = (wr_req && fifo_full) ||
                   (state == SHIFT && fifo_wr_level > LVL_W'(LINE_W));
  assign udf_evt = rd_req && fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_entry) begin
      err_ovf_r <= 1'b0;
      err_udf_r <= 1'b0;
    end else begin
      if (ovf_evt) err_ovf_r <= 1'b1;
      if (udf_evt) err_udf_r <= 1'b1;
    end
  end

  assign err_ovf = err_ovf_r;
  assign err_udf = err_udf_r;
`else
  logic unused_lvl;
  assign unused_lvl = ^fifo_wr_level;
  assign err_ovf    = 1'b0;
  assign err_udf    = 1'b0;
`endif

endmodule

// File: tb/tb_line_shift_ctrl.sv
// Directed bench for line_shift_ctrl (LINE_W=8) with a behavioural line FIFO model;
// error-flag expectations follow LINE_SHIFT_ERR_EN.
module tb_line_shift_ctrl;
  localparam int DATA_W     = 8;
  localparam int LINE_W     = 8;
  localparam int LVL_W      = 12;
  localparam int CLR_CYCLES = 2;
`ifdef LINE_SHIFT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, frame_start, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              fifo_rst, fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_wr_data, fifo_rd_data;
  logic [LVL_W-1:0]  fifo_wr_level;
  logic              out_valid, err_ovf, err_udf;
  logic [DATA_W-1:0] out_cur, out_prev;
  logic [11:0]       line_cnt;

  always #5 clk = ~clk;

  line_shift_ctrl #(
    .DATA_W(DATA_W), .LINE_W(LINE_W), .LVL_W(LVL_W), .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_level(fifo_wr_level),
    .out_valid(out_valid), .out_cur(out_cur), .out_prev(out_prev),
    .line_cnt(line_cnt), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  // Behavioural 2048-deep FIFO with 1-cycle read latency and overridable flags.
  logic [DATA_W-1:0] q[$];
  int                lvl = 0;
  bit                force_full = 1'b0, force_empty = 1'b0;

  assign fifo_full     = force_full || (lvl >= 2048);
  assign fifo_empty    = force_empty || (lvl == 0);
  assign fifo_wr_level = LVL_W'(lvl);

  always @(posedge clk) begin
    if (fifo_rst) begin
      q.delete();
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en) fifo_rd_data <= q.pop_front();
      if (fifo_wr_en) q.push_back(fifo_wr_data);
    end
    lvl <= q.size();
  end

  int n_cmp = 0, n_err = 0;
  bit                pend_ov = 1'b0;
  logic [DATA_W-1:0] pend_cur = '0, pend_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs at the falling edge, record the pair due next cycle.
  task automatic step(input bit fs, input bit v, input logic [DATA_W-1:0] d,
                      input bit exp_rst, input bit exp_wr, input bit exp_rd,
                      input logic [DATA_W-1:0] exp_prev);
    frame_start = fs;
    in_valid    = v;
    in_data     = d;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(pend_ov));
    if (pend_ov) begin
      check("out_cur", 32'(out_cur), 32'(pend_cur));
      check("out_prev", 32'(out_prev), 32'(pend_prev));
    end
    check("fifo_rst", 32'(fifo_rst), 32'(exp_rst));
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    if (exp_wr) check("fifo_wr_data", 32'(fifo_wr_data), 32'(d));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    pend_ov   = exp_rd;
    pend_cur  = d;
    pend_prev = exp_prev;
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < CLR_CYCLES; c++)
      step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;

    // Reset held for 3 cycles with stray pixels present.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_fifo_rst", 32'(fifo_rst), 32'd1);
    check("rst_out_cur", 32'(out_cur), 32'd0);
    check("rst_out_prev", 32'(out_prev), 32'd0);
    check("rst_line_cnt", 32'(line_cnt), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    check("rst_err_udf", 32'(err_udf), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores in_valid.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00);

    // Continuous stream, two lines.
    new_frame();
    check("clear_line_cnt", 32'(line_cnt), 32'd0);
    for (int p = 0; p < 16; p++)
      step(1'b0, 1'b1, 8'(p), 1'b0, 1'b1, p >= LINE_W, 8'(p - LINE_W));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("cont_line_cnt", 32'(line_cnt), 32'd2);
    check("cont_level", 32'(lvl), 32'd8);

    // Gapped stream (valid every 3rd cycle), three lines.
    new_frame();
    for (int p = 0; p < 24; p++) begin
      step(1'b0, 1'b1, 8'(p), 1'b0, 1'b1, p >= LINE_W, 8'(p - LINE_W));
      if (p >= LINE_W) check("gap_level", 32'(lvl), 32'd8);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    check("gap_line_cnt", 32'(line_cnt), 32'd3);

    // Abort after 5 pixels of line 2.
    new_frame();
    for (int p = 0; p < 13; p++)
      step(1'b0, 1'b1, 8'(p), 1'b0, 1'b1, p >= LINE_W, 8'(p - LINE_W));
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00);
    check("abort_level", 32'(lvl), 32'd0);
    check("abort_line_cnt", 32'(line_cnt), 32'd0);
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int p = 0; p < LINE_W; p++)
      step(1'b0, 1'b1, 8'(8'h40 + p), 1'b0, 1'b1, 1'b0, 8'h00);
    check("refill_line_cnt", 32'(line_cnt), 32'd1);
    check("refill_level", 32'(lvl), 32'd8);

    // Underflow guard in SHIFT.
    force_empty = 1'b1;
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00);
    force_empty = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("udf_flag", 32'(err_udf), 32'(ERR_EN));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("udf_sticky", 32'(err_udf), 32'(ERR_EN));
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("udf_cleared", 32'(err_udf), 32'd0);
    check("ovf_cleared", 32'(err_ovf), 32'd0);
    for (int c = 0; c < CLR_CYCLES; c++)
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

    // Overflow guard in FILL.
    force_full = 1'b1;
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00);
    force_full = 1'b0;
    check("ovf_flag", 32'(err_ovf), 32'(ERR_EN));
    check("ovf_no_udf", 32'(err_udf), 32'd0);
    step(1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00);
    check("ovf_level", 32'(lvl), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
